fps_meter_sched: RTL and testbench

Time-multiplexed frame-rate measurement scheduler for the video pipeline. It shares one frame-edge counter and one gate timer between up to NUM_CH asynchronous frame-sync sources, for example camera VSYNC, Sobel output VSYNC and HDMI VSYNC. Enabled channels are served round-robin, one fixed gate window each. Each result is held in a per-channel register, and the seven-segment display path reads any channel through a registered read port.

---
 rtl/fps_meter_sched.sv | 129 ++++++++++++
 tb/tb_fps_meter_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fps_meter_sched.sv
// Round-robin frame-rate meter: one shared gate timer and edge counter serve each
// enabled vsync channel for a fixed window; per-channel results sit behind a registered read port.
module fps_meter_sched #(
  parameter int NUM_CH      = 4,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 20,
  localparam int SEL_W      = $clog2(NUM_CH),
  localparam int GATE_W     = $clog2(GATE_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] vsync,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              run,
  input  logic [SEL_W-1:0]  sel,
  output logic [CNT_W-1:0]  rd_fps,
  output logic              rd_valid,
  output logic              busy,
  output logic [SEL_W-1:0]  cur_ch,
  output logic              done,
  output logic [SEL_W-1:0]  done_ch
);

  typedef enum logic [2:0] {IDLE, SELECT, ARM, GATE, STORE} state_t;

  state_t            state;
  logic [NUM_CH-1:0] sync1, sync2, prev, edges;
  logic [SEL_W-1:0]  last_ch, next_ch, cand;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  result [NUM_CH];
  logic [NUM_CH-1:0] valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= vsync;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edges = sync2 & ~prev;

  // Scan downward so the nearest enabled channel after last_ch wins.
  always_comb begin
    next_ch = last_ch;
    cand    = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = SEL_W'((int'(last_ch) + k) % NUM_CH);
      if (ch_en[cand]) next_ch = cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_ch  <= SEL_W'(NUM_CH - 1);
      cur_ch   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_ch  <= '0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      valid    <= '0;
      rd_fps   <= '0;
      rd_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
    end else begin
      done     <= 1'b0;
      rd_fps   <= result[sel];
      rd_valid <= valid[sel];
      // Forward the value being stored so the read port sees it one cycle after STORE.
      if (state == STORE && sel == cur_ch) begin
        rd_fps   <= edge_cnt;
        rd_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (run && |ch_en) state <= SELECT;
        end
        SELECT: begin
          if (!run || ch_en == '0) begin
            state <= IDLE;
          end else begin
            cur_ch <= next_ch;
            busy   <= 1'b1;
            state  <= ARM;
          end
        end
        ARM, GATE: begin
          if (!run) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!ch_en[cur_ch]) begin
            last_ch <= cur_ch;
            state   <= SELECT;
            busy    <= 1'b0;
          end else if (state == ARM) begin
            edge_cnt <= '0;
            gate_cnt <= '0;
            state    <= GATE;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            if (edges[cur_ch] && edge_cnt != '1) edge_cnt <= edge_cnt + 1'b1;
            if (gate_cnt == GATE_W'(GATE_CYCLES - 1)) begin
              state   <= STORE;
              busy    <= 1'b0;
              done    <= 1'b1;
              done_ch <= cur_ch;
            end
          end
        end
        STORE: begin
          result[cur_ch] <= edge_cnt;
          valid[cur_ch]  <= 1'b1;
          last_ch        <= cur_ch;
          state          <= SELECT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fps_meter_sched.sv
// Scoreboard bench for fps_meter_sched: periodic vsync sources give exact per-window counts.
module tb_fps_meter_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  vsync, ch_en;
  logic        run;
  logic [1:0]  sel;
  logic [19:0] rd_fps;
  logic        rd_valid, busy, done;
  logic [1:0]  cur_ch, done_ch;

  logic [1:0]  vsync_s, ch_en_s;
  logic        run_s;
  logic [0:0]  sel_s, cur_ch_s, done_ch_s;
  logic [3:0]  rd_fps_s;
  logic        rd_valid_s, busy_s, done_s;

  typedef struct {int ch; int val;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int per [4] = '{10, 20, 16, 25};

  fps_meter_sched #(.NUM_CH(4), .GATE_CYCLES(100), .CNT_W(20)) u_dut (
    .clk(clk), .rst(rst), .vsync(vsync), .ch_en(ch_en), .run(run), .sel(sel),
    .rd_fps(rd_fps), .rd_valid(rd_valid), .busy(busy), .cur_ch(cur_ch),
    .done(done), .done_ch(done_ch)
  );

  fps_meter_sched #(.NUM_CH(2), .GATE_CYCLES(100), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .vsync(vsync_s), .ch_en(ch_en_s), .run(run_s), .sel(sel_s),
    .rd_fps(rd_fps_s), .rd_valid(rd_valid_s), .busy(busy_s), .cur_ch(cur_ch_s),
    .done(done_s), .done_ch(done_ch_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Wait for n done pulses, popping one expectation per pulse.
  task automatic drain(input int n, input bit chk_period);
    int   last_t = -1;
    int   waited;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!done && waited < 400);
      if (!done) begin
        check("done_timeout", done, 1);
        sb.delete();
        return;
      end
      e = sb.pop_front();
      check("done_ch", done_ch, e.ch);
      check("busy_in_store", busy, 0);
      if (chk_period && last_t >= 0) check("slot_len", cyc - last_t, 103);
      last_t = cyc;
      sel = 2'(e.ch);
      @(negedge clk);
      check("rd_fps", rd_fps, e.val);
      check("rd_valid", rd_valid, 1);
    end
  endtask

  initial begin
    vsync   = '0;
    vsync_s = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) vsync[i] = (cyc % per[i]) < (per[i] / 2);
      vsync_s[0] = (cyc % 4) < 2;
      vsync_s[1] = (cyc % 8) < 4;
    end
  end

  initial begin
    int ndone;
    int waited;
    rst = 1'b1; run = 1'b0; ch_en = '0; sel = '0;
    run_s = 1'b0; ch_en_s = '0; sel_s = '0;
    repeat (3) @(negedge clk);
    check("rst_rd_fps", rd_fps, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_ch", cur_ch, 0);
    check("rst_done", done, 0);
    check("rst_done_ch", done_ch, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single channel, plus run-to-ARM latency.
    ch_en = 4'b0001; run = 1'b1;
    @(negedge clk);
    check("busy_select", busy, 0);
    @(negedge clk);
    check("busy_arm", busy, 1);
    check("cur_ch_arm", cur_ch, 0);
    repeat (3) sb.push_back('{0, 10});
    drain(3, 1);

    // Round robin over 1011; last_ch is 0 here so channel 1 comes first.
    run = 1'b0;
    @(negedge clk);
    ch_en = 4'b1011;
    @(negedge clk);
    check("idle_busy", busy, 0);
    run = 1'b1;
    sb.push_back('{1, 5}); sb.push_back('{3, 4}); sb.push_back('{0, 10});
    sb.push_back('{1, 5}); sb.push_back('{3, 4}); sb.push_back('{0, 10});
    drain(6, 1);
    run = 1'b0;

    // Read port latency and disabled channel.
    sel = 2'd2; @(negedge clk);
    check("ch2_valid", rd_valid, 0);
    check("ch2_fps", rd_fps, 0);
    sel = 2'd1; @(negedge clk);
    check("sel1_fps", rd_fps, 5);
    sel = 2'd3; @(negedge clk);
    check("sel3_fps", rd_fps, 4);
    sel = 2'd0; @(negedge clk);
    check("sel0_fps", rd_fps, 10);

    // Abort by dropping run mid-gate.
    ch_en = 4'b0001; run = 1'b1;
    repeat (52) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    ndone = 0;
    repeat (150) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_result", rd_fps, 10);

    // Saturation: 25 edges per window into a 4-bit counter.
    ch_en_s = 2'b01; run_s = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!done_s && waited < 400);
    check("sat_done", done_s, 1);
    @(negedge clk);
    check("sat_fps", rd_fps_s, 15);
    check("sat_valid", rd_valid_s, 1);
    run_s = 1'b0;

    // Asynchronous reset mid-gate with results present.
    ch_en = 4'b0001; run = 1'b1;
    repeat (2 + $urandom_range(20, 80)) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rd_fps", rd_fps, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sel = 2'd1;
    @(negedge clk);
    check("valid_cleared", rd_valid, 0);
    repeat (10) @(negedge clk);

    // First slot after reset is channel 0; then enable-abort on channel 0.
    ch_en = 4'b0011; run = 1'b1;
    sb.push_back('{0, 10}); sb.push_back('{1, 5});
    drain(2, 1);
    @(negedge clk);
    check("abort_ch_cur", cur_ch, 0);
    repeat (30) @(negedge clk);
    ch_en = 4'b0010;
    sb.push_back('{1, 5});
    drain(1, 0);
    sel = 2'd0;
    @(negedge clk);
    check("ch0_kept", rd_fps, 10);
    run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
